// File: rtl/axi_req_master_if.sv
// Bus bundle for axi_req_master: the request stream plus the five AXI4-Lite master channels.
// The master modport is the DUT view; the slave modport is the view of whatever drives requests and answers the bus.
interface axi_req_master_if;
  logic [71:0] AXI_REQ_TDATA;
  logic        AXI_REQ_TVALID;
  logic        AXI_REQ_TREADY;

  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [31:0] M_AXI_ARADDR;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    input  AXI_REQ_TDATA, AXI_REQ_TVALID,
    output AXI_REQ_TREADY,
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output AXI_REQ_TDATA, AXI_REQ_TVALID,
    input  AXI_REQ_TREADY,
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_req_master.sv
// Request-stream to AXI4-Lite master: buffers requests in a FIFO and issues them one at a time.
// Optional macro RSP_STREAM_EN adds an AXI-Stream response output that holds the RSP state until accepted.
module axi_req_master #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  axi_req_master_if.master       bus,
  output logic [31:0]            last_rdata,
  output logic [1:0]             last_resp,
  output logic                   overflow,
  output logic                   busy
`ifdef RSP_STREAM_EN
  ,
  output logic [63:0]            AXIS_RSP_TDATA,
  output logic                   AXIS_RSP_TVALID,
  input  logic                   AXIS_RSP_TREADY
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_e;

  state_e             state_q, state_d;
  logic [64:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
  logic               aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [31:0]        last_rdata_q, last_rdata_d;
  logic [1:0]         last_resp_q, last_resp_d;
  logic               overflow_q, overflow_d;
  logic               full, empty, push, pop;
  logic [64:0]        head;
  logic               unused_tdata;

  assign unused_tdata = ^bus.AXI_REQ_TDATA[71:65];

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // A pop in the same cycle never frees room for a push: readiness is judged on the registered count.
  assign push  = bus.AXI_REQ_TVALID && !full;
  assign pop   = (state_q == IDLE) && !empty;
  assign head  = mem_q[rd_ptr_q];

  assign bus.AXI_REQ_TREADY = !full;
  assign bus.M_AXI_AWADDR   = addr_q;
  assign bus.M_AXI_AWVALID  = (state_q == WR_ADDR) && !aw_done_q;
  assign bus.M_AXI_WDATA    = wdata_q;
  assign bus.M_AXI_WSTRB    = 4'hF;
  assign bus.M_AXI_WVALID   = (state_q == WR_ADDR) && !w_done_q;
  assign bus.M_AXI_BREADY   = (state_q == WR_RESP);
  assign bus.M_AXI_ARADDR   = addr_q;
  assign bus.M_AXI_ARVALID  = (state_q == RD_ADDR);
  assign bus.M_AXI_RREADY   = (state_q == RD_DATA);

  assign last_rdata = last_rdata_q;
  assign last_resp  = last_resp_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) || !empty;

`ifdef RSP_STREAM_EN
  logic mode_q, mode_d;

  assign AXIS_RSP_TVALID = (state_q == RSP);
  assign AXIS_RSP_TDATA  = {29'd0, mode_q, last_resp_q, (mode_q ? 32'd0 : last_rdata_q)};
`endif

  // NOTE: every variable gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    last_rdata_d = last_rdata_q;
    last_resp_d  = last_resp_q;
    overflow_d   = overflow_q | (bus.AXI_REQ_TVALID && full);
`ifdef RSP_STREAM_EN
    mode_d       = mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (!empty) begin
          addr_d  = head[31:0];
          wdata_d = head[63:32];
          state_d = head[64] ? WR_ADDR : RD_ADDR;
`ifdef RSP_STREAM_EN
          mode_d  = head[64];
`endif
        end
      end
      WR_ADDR: begin
        // VALID is already low once its *_done flag is set, so READY alone marks the handshake.
        aw_done_d = aw_done_q | bus.M_AXI_AWREADY;
        w_done_d  = w_done_q  | bus.M_AXI_WREADY;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bus.M_AXI_BVALID) begin
          last_resp_d = bus.M_AXI_BRESP;
          state_d     = RSP;
        end
      end
      RD_ADDR: begin
        if (bus.M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.M_AXI_RVALID) begin
          last_rdata_d = bus.M_AXI_RDATA;
          last_resp_d  = bus.M_AXI_RRESP;
          state_d      = RSP;
        end
      end
      RSP: begin
`ifdef RSP_STREAM_EN
        if (AXIS_RSP_TREADY) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      last_rdata_q <= '0;
      last_resp_q  <= '0;
      overflow_q   <= 1'b0;
`ifdef RSP_STREAM_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      last_rdata_q <= last_rdata_d;
      last_resp_q  <= last_resp_d;
      overflow_q   <= overflow_d;
`ifdef RSP_STREAM_EN
      mode_q       <= mode_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.AXI_REQ_TDATA[64:0];
  end

endmodule
